// File: rtl/parking_gate_ctrl.sv
// ============================================================================
// Module   : parking_gate_ctrl
// Purpose  : N-slot parking controller. It synchronises the sensors and runs
//            the entrance and exit gate FSMs. It tracks occupied and pending
//            (admitted, not yet parked) cars and drives the slot and full LEDs.
//            Optional reservation timeout: `define PARKING_GATE_TIMEOUT_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module parking_gate_ctrl #(
    parameter int NUM_SLOTS     = 3,
    parameter int HOLD_TICKS    = 2,
    parameter int TIMEOUT_TICKS = 25,
    parameter int CNT_W         = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [NUM_SLOTS-1:0] slot_presence,
    input  logic                 entr_presence,
    input  logic                 exit_presence,
    output logic [NUM_SLOTS-1:0] slot_led,
    output logic                 full_led,
    output logic                 open_entrance,
    output logic                 open_exit,
    output logic [CNT_W-1:0]     occupied_count,
    output logic [CNT_W-1:0]     pending_count,
    output logic                 car_enter,
    output logic                 car_exit
);

    localparam int              c_HOLD_W    = $clog2(HOLD_TICKS + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLD_TICKS);
    localparam logic [1:0]      c_S_IDLE    = 2'd0;
    localparam logic [1:0]      c_S_OPEN    = 2'd1;
    localparam logic [1:0]      c_S_HOLD    = 2'd2;

    if (NUM_SLOTS < 1 || NUM_SLOTS > 15) begin : g_chk_slots
        $error("parking_gate_ctrl: NUM_SLOTS out of range");
    end
    if (HOLD_TICKS < 1) begin : g_chk_hold
        $error("parking_gate_ctrl: HOLD_TICKS must be >= 1");
    end
    if (TIMEOUT_TICKS < 1) begin : g_chk_timeout
        $error("parking_gate_ctrl: TIMEOUT_TICKS must be >= 1");
    end
    if ((1 << CNT_W) <= NUM_SLOTS) begin : g_chk_cnt_w
        $error("parking_gate_ctrl: CNT_W too narrow for NUM_SLOTS");
    end

    logic [NUM_SLOTS-1:0] r_slot_s1, r_slot_s2;
    logic [1:0]           r_gate_s1, r_gate_s2;   // [0]=entrance, [1]=exit
    logic [NUM_SLOTS-1:0] r_slot_led;
    logic [CNT_W-1:0]     r_occ, r_pend;
    logic                 r_full;
    logic [CNT_W-1:0]     w_pop, w_park, w_pend_nxt;
    logic [CNT_W+1:0]     w_pend_add, w_pend_dec, w_pend_diff;
    logic [1:0]           w_allow, w_open, w_pulse;
    logic                 w_capacity_ok, w_enter_start, w_expire;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_s1  <= '0;
            r_slot_s2  <= '0;
            r_gate_s1  <= '0;
            r_gate_s2  <= '0;
            r_slot_led <= '0;
            r_occ      <= '0;
            r_full     <= 1'b0;
            r_pend     <= '0;
        end else begin
            r_slot_s1  <= slot_presence;
            r_slot_s2  <= r_slot_s1;
            r_gate_s1  <= {exit_presence, entr_presence};
            r_gate_s2  <= r_gate_s1;
            r_slot_led <= r_slot_s2;
            r_occ      <= w_pop;
            r_full     <= (r_occ == CNT_W'(NUM_SLOTS));
            r_pend     <= w_pend_nxt;
        end
    end

    // r_slot_led is the previous synchronised sample, so it doubles as the edge reference
    always_comb begin
        w_pop  = '0;
        w_park = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_pop  = w_pop + CNT_W'(r_slot_s2[i]);
            w_park = w_park + CNT_W'(r_slot_s2[i] & ~r_slot_led[i]);
        end
    end

    assign w_capacity_ok = ({1'b0, r_occ} + {1'b0, r_pend}) < (CNT_W + 1)'(NUM_SLOTS);
    assign w_allow       = {1'b1, w_capacity_ok};

    for (genvar gi = 0; gi < 2; gi++) begin : g_gate
        logic [1:0]          r_state, w_nxt_state;
        logic [c_HOLD_W-1:0] r_hold, w_nxt_hold;
        logic                r_pulse, w_start;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= c_S_IDLE;
                r_hold  <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_state <= w_nxt_state;
                r_hold  <= w_nxt_hold;
                r_pulse <= w_start;
            end
        end

        // A state exit takes priority over a coincident tick
        always_comb begin
            w_nxt_state = r_state;
            w_nxt_hold  = r_hold;
            w_start     = 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (r_gate_s2[gi] && w_allow[gi]) begin
                        w_nxt_state = c_S_OPEN;
                        w_start     = 1'b1;
                    end
                end
                c_S_OPEN: begin
                    if (!r_gate_s2[gi]) begin
                        w_nxt_state = c_S_HOLD;
                        w_nxt_hold  = c_HOLD_LOAD;
                    end
                end
                c_S_HOLD: begin
                    if (r_gate_s2[gi]) begin
                        w_nxt_state = c_S_OPEN;
                    end else if (r_hold == '0) begin
                        w_nxt_state = c_S_IDLE;
                    end else if (tick) begin
                        w_nxt_hold = r_hold - 1'b1;
                    end
                end
                default: w_nxt_state = c_S_IDLE;
            endcase
        end

        assign w_open[gi]  = (r_state != c_S_IDLE);
        assign w_pulse[gi] = r_pulse;
    end

    assign w_enter_start = g_gate[0].w_start;

`ifdef PARKING_GATE_TIMEOUT_EN
    localparam int               c_TMO_W    = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LOAD = c_TMO_W'(TIMEOUT_TICKS);
    logic [c_TMO_W-1:0] r_tmo;

    assign w_expire = tick && (r_tmo == c_TMO_W'(1)) && (r_pend != '0);

    // Zero means idle; the timer is shared and restarted on any pending change that leaves cars waiting
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo <= '0;
        end else if (w_enter_start) begin
            r_tmo <= c_TMO_LOAD;
        end else if (w_pend_nxt == '0) begin
            r_tmo <= '0;
        end else if ((w_park != '0) || w_expire) begin
            r_tmo <= c_TMO_LOAD;
        end else if (tick && (r_tmo != '0)) begin
            r_tmo <= r_tmo - 1'b1;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    // Admission and parking in the same cycle net out; result clamps to [0, NUM_SLOTS]
    always_comb begin
        w_pend_add  = {2'b00, r_pend} + (CNT_W + 2)'(w_enter_start);
        w_pend_dec  = {2'b00, w_park} + (CNT_W + 2)'(w_expire);
        w_pend_diff = '0;
        if (w_pend_add > w_pend_dec) begin
            w_pend_diff = w_pend_add - w_pend_dec;
        end
        if (w_pend_diff > (CNT_W + 2)'(NUM_SLOTS)) begin
            w_pend_diff = (CNT_W + 2)'(NUM_SLOTS);
        end
        w_pend_nxt = CNT_W'(w_pend_diff);
    end

    assign slot_led       = r_slot_led;
    assign full_led       = r_full;
    assign occupied_count = r_occ;
    assign pending_count  = r_pend;
    assign open_entrance  = w_open[0];
    assign open_exit      = w_open[1];
    assign car_enter      = w_pulse[0];
    assign car_exit       = w_pulse[1];

endmodule

`default_nettype wire

// File: tb/tb_parking_gate_ctrl.sv
// ============================================================================
// Module   : tb_parking_gate_ctrl
// Purpose  : Directed bench for parking_gate_ctrl. Gate pulses are checked
//            against a scoreboard queue; levels are checked inline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parking_gate_ctrl;

    localparam int c_N  = 3;
    localparam int c_CW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            tick;
    logic [c_N-1:0]  slot_presence;
    logic            entr_presence;
    logic            exit_presence;
    logic [c_N-1:0]  slot_led;
    logic            full_led;
    logic            open_entrance;
    logic            open_exit;
    logic [c_CW-1:0] occupied_count;
    logic [c_CW-1:0] pending_count;
    logic            car_enter;
    logic            car_exit;

    parking_gate_ctrl #(
        .NUM_SLOTS     (c_N),
        .HOLD_TICKS    (2),
        .TIMEOUT_TICKS (25),
        .CNT_W         (c_CW)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .tick           (tick),
        .slot_presence  (slot_presence),
        .entr_presence  (entr_presence),
        .exit_presence  (exit_presence),
        .slot_led       (slot_led),
        .full_led       (full_led),
        .open_entrance  (open_entrance),
        .open_exit      (open_exit),
        .occupied_count (occupied_count),
        .pending_count  (pending_count),
        .car_enter      (car_enter),
        .car_exit       (car_exit)
    );

    always #5 clk = ~clk;

    int r_cyc = 0;
    always @(posedge clk) r_cyc <= r_cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit is_exit;
        int at_cyc;
        int pend;
    } ev_t;
    ev_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, r_cyc);
        end
    endtask

    task automatic expect_event(input bit is_exit, input int delay, input int pend);
        ev_t e;
        e.is_exit = is_exit;
        e.at_cyc  = r_cyc + delay;
        e.pend    = pend;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input bit is_exit);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pulse: got %s pulse at cycle %0d, expected none",
                     is_exit ? "car_exit" : "car_enter", r_cyc);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind",    32'(is_exit), 32'(e.is_exit));
            check("ev_cycle",   r_cyc,        e.at_cyc);
            check("ev_pending", 32'(pending_count), e.pend);
        end
    endtask

    // Monitor: every gate pulse consumes one scoreboard entry
    always @(negedge clk) begin
        if (car_enter === 1'b1) sb_pop(1'b0);
        if (car_exit === 1'b1)  sb_pop(1'b1);
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cycles(1);
        tick = 1'b0;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({slot_led, full_led, open_entrance, open_exit,
                    occupied_count, pending_count, car_enter, car_exit});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; tick = 1'b0; slot_presence = '0;
        entr_presence = 1'b0; exit_presence = 1'b0;
        cycles(3);
        check("reset_outs", all_outs(), 0);
        reset = 1'b0;
        cycles(1);

        // Single admission, hold released by two ticks
        entr_presence = 1'b1;
        expect_event(1'b0, 3, 1);
        cycles(10);
        check("s1_open", 32'(open_entrance), 1);
        entr_presence = 1'b0;
        cycles(3);
        check("s1_open_hold", 32'(open_entrance), 1);
        do_tick();
        cycles(2);
        check("s1_open_tick1", 32'(open_entrance), 1);
        do_tick();
        check("s1_open_tick2", 32'(open_entrance), 1);
        cycles(1);
        check("s1_closed", 32'(open_entrance), 0);
        check("s1_pending", 32'(pending_count), 1);

        // Car parks in slot 0
        slot_presence = 3'b001;
        cycles(2);
        check("s2_led_early", 32'(slot_led), 0);
        cycles(1);
        check("s2_led", 32'(slot_led), 1);
        check("s2_occ", 32'(occupied_count), 1);
        check("s2_pending", 32'(pending_count), 0);

        // Full lot: car waits, admitted once slot 1 frees
        slot_presence = 3'b111;
        cycles(4);
        check("s3_occ", 32'(occupied_count), 3);
        check("s3_full", 32'(full_led), 1);
        check("s3_pend_sat", 32'(pending_count), 0);
        entr_presence = 1'b1;
        cycles(6);
        check("s3_full_closed", 32'(open_entrance), 0);
        slot_presence = 3'b101;
        expect_event(1'b0, 4, 1);
        cycles(5);
        check("s3_open", 32'(open_entrance), 1);
        check("s3_full_clr", 32'(full_led), 0);
        check("s3_occ2", 32'(occupied_count), 2);

        // occupied 2 + pending 1: second car must wait, still waits after the park fills the lot
        entr_presence = 1'b0;
        cycles(3);
        do_tick();
        do_tick();
        cycles(1);
        check("s4_closed", 32'(open_entrance), 0);
        entr_presence = 1'b1;
        cycles(6);
        check("s4_wait", 32'(open_entrance), 0);
        check("s4_pending", 32'(pending_count), 1);
        slot_presence = 3'b111;
        cycles(4);
        check("s4_occ", 32'(occupied_count), 3);
        check("s4_pend0", 32'(pending_count), 0);
        check("s4_still_closed", 32'(open_entrance), 0);
        entr_presence = 1'b0;
        cycles(3);

        // Exit during entrance hold: both gates open, each times out on its own
        slot_presence = 3'b110;
        cycles(4);
        check("s5_occ", 32'(occupied_count), 2);
        entr_presence = 1'b1;
        expect_event(1'b0, 3, 1);
        cycles(4);
        entr_presence = 1'b0;
        cycles(3);
        exit_presence = 1'b1;
        expect_event(1'b1, 3, 1);
        do_tick();
        cycles(2);
        check("s5_both_entr", 32'(open_entrance), 1);
        check("s5_both_exit", 32'(open_exit), 1);
        exit_presence = 1'b0;
        do_tick();
        check("s5_entr_last", 32'(open_entrance), 1);
        cycles(1);
        check("s5_entr_closed", 32'(open_entrance), 0);
        check("s5_exit_open", 32'(open_exit), 1);
        cycles(1);
        do_tick();
        do_tick();
        check("s5_exit_last", 32'(open_exit), 1);
        cycles(1);
        check("s5_exit_closed", 32'(open_exit), 0);

        // Reset while the entrance is open
        slot_presence = 3'b010;
        cycles(4);
        entr_presence = 1'b1;
        expect_event(1'b0, 3, 2);
        cycles(4);
        check("s6_open", 32'(open_entrance), 1);
        reset = 1'b1;
        entr_presence = 1'b0;
        slot_presence = '0;
        cycles(1);
        check("s6_reset_outs", all_outs(), 0);
        cycles(1);
        reset = 1'b0;
        cycles(4);
        check("s6_after_reset", all_outs(), 0);

`ifdef PARKING_GATE_TIMEOUT_EN
        // Admitted car never parks: reservation dropped on the 25th tick
        entr_presence = 1'b1;
        expect_event(1'b0, 3, 1);
        cycles(4);
        entr_presence = 1'b0;
        cycles(4);
        for (int i = 0; i < 24; i++) begin
            do_tick();
            cycles(1);
        end
        check("tmo_before", 32'(pending_count), 1);
        do_tick();
        check("tmo_expired", 32'(pending_count), 0);
        cycles(2);
`endif

        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
